// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_mem_loader_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DEPTH_DEF  = 1024;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port.
// The loader sits on the slave side: it consumes bytes and drives the memory write.
interface instr_mem_loader_if
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_data
    );

endinterface

// File: rtl/instr_mem_loader_packer.sv
// Assembles four big-endian bytes into one 32-bit word.
// o_word is only meaningful in the cycle o_word_valid is high (4th byte shifting in).
module instr_mem_loader_packer
    import instr_mem_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid
);

    logic [23:0] r_shift;
    logic [1:0]  r_cnt;

    assign o_word       = {r_shift, i_byte};
    assign o_word_valid = i_shift && !i_clear && (r_cnt == 2'd3);

    // Shift bytes in MSB-first; the counter wraps to 0 after the 4th byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte stream into instruction memory as 32-bit words from address 0,
// holding the CPU while the load runs.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for Start; Length is range-checked on acceptance
// ST_RECV  | accepting bytes until a full word is assembled
// ST_WRITE | one-cycle memory write of the assembled word
// ST_FIN   | one-cycle Done pulse, CPU still held
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_length,
    input  logic              i_abort,
    instr_mem_loader_if.slave bus,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_idx;
    logic              r_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_data;
    logic              r_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic              w_xfer;
    logic              w_clear;
    logic [WORD_W-1:0] w_word;
    logic              w_word_valid;
    logic [ADDR_W:0]   w_idx_next;

    // A partial word is dropped whenever we leave RECV other than via a full word.
    assign w_xfer     = bus.byte_valid && r_ready;
    assign w_clear    = (r_state != ST_RECV) || i_abort;
    assign w_idx_next = r_idx + LP_ONE;

    instr_mem_loader_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_clear),
        .i_shift      (w_xfer),
        .i_byte       (bus.byte_in),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    assign bus.byte_ready = r_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_data   = r_mem_data;
    assign o_cpu_hold     = r_hold;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;

    // Load sequencer; every output is registered alongside the state transition.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_idx      <= '0;
            r_ready    <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_hold     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_error <= 1'b0;
                        r_len   <= i_length;
                        r_idx   <= '0;
                        if (i_length == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b1;
                            r_hold  <= 1'b1;
                        end else if (i_length > LP_DEPTH) begin
                            r_error <= 1'b1;
                        end else begin
                            r_state <= ST_RECV;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                            r_hold  <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b0;
                        r_hold  <= 1'b0;
                    end else if (w_word_valid) begin
                        r_state    <= ST_WRITE;
                        r_ready    <= 1'b0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_idx[ADDR_W-1:0];
                        r_mem_data <= w_word;
                    end
                end
                ST_WRITE: begin
                    r_idx <= w_idx_next;
                    if (i_abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_hold  <= 1'b0;
                    end else if (w_idx_next == r_len) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_RECV;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Write-side counterpart to the instruction memory. It accepts a big-endian byte stream over a valid/ready handshake and assembles it into 32-bit MIPS instruction words. It writes those words to consecutive instruction-memory addresses starting at 0. It holds the pipeline CPU stalled while a load is in progress and reports completion or error to the boot/debug controller.

Parameters:
ADDR_W, 10, word-address width of instruction memory
DEPTH, 1024, number of 32-bit words writable (valid addresses 0..DEPTH-1)

Ports:
Clk  in  1  system clock, all state on rising edge
Rst_n  in  1  asynchronous active-low reset
Start  in  1  one-cycle request to begin a load; sampled only in IDLE
Length  in  ADDR_W+1  number of words to load, sampled when Start is accepted
Abort  in  1  synchronous cancel of a load in progress
Byte_In  in  8  stream byte
Byte_Valid  in  1  Byte_In is valid
Byte_Ready  out  1  loader accepts a byte this cycle
Mem_We  out  1  instruction-memory write enable, one cycle per word
Mem_Addr  out  ADDR_W  word address of the write
Mem_Data  out  32  instruction word to write
Cpu_Hold  out  1  stall/hold-in-reset request to the CPU
Busy  out  1  load in progress
Done  out  1  one-cycle pulse when a load completes successfully
Error  out  1  sticky; set on a rejected Length; cleared by the next accepted Start

Behaviour:
- Reset (Rst_n=0, asynchronous): state IDLE.
  - Byte_Ready, Mem_We, Cpu_Hold, Busy, Done and Error are all 0.
  - Mem_Addr=0, Mem_Data=0, byte counter=0, word index=0.
- A byte transfer occurs on any rising edge where Byte_Valid=1 and Byte_Ready=1. No transfer occurs otherwise; Byte_In is don't-care when Byte_Valid=0.
- FSM states: IDLE, RECV, WRITE, FIN.
- IDLE:
  - Byte_Ready=0.
  - On Start=1 (and Abort=0), latch Length, clear Error, set word index=0 and byte counter=0.
  - Then: Length=0 → FIN. Length>DEPTH → set Error, go to IDLE, perform no writes, no Done. Otherwise → RECV.
- RECV:
  - Byte_Ready=1, Busy=1, Cpu_Hold=1.
  - Each transfer shifts the byte into the assembly register MSB-first: the first byte lands in bits [31:24], the fourth in [7:0].
  - On the 4th transfer: register the full word into Mem_Data, register the word index into Mem_Addr, go to WRITE.
- WRITE (exactly one cycle):
  - Mem_We=1, Byte_Ready=0.
  - Increment the word index and reset the byte counter.
  - If the new index equals Length → FIN, else → RECV.
- FIN (exactly one cycle): Done=1, Cpu_Hold=1, Busy=1; then → IDLE, where Busy and Cpu_Hold drop.
- Latency and throughput:
  - 4th byte accepted at edge N → Mem_We high during cycle N+1 → next byte can be accepted at edge N+2.
  - Peak throughput is 4 bytes per 5 cycles.
  - Final write is cycle N+1, Done is cycle N+2, Cpu_Hold falls in cycle N+3.
- Mem_We is never asserted outside WRITE. Mem_Addr and Mem_Data hold their last values otherwise.
- Word index and Mem_Addr never exceed Length-1 ≤ DEPTH-1, so no wrap-around is possible. A Length of exactly DEPTH writes address DEPTH-1 last.
- Start while not IDLE is ignored. Length changes after acceptance are ignored.
- Abort=1 in RECV, WRITE or FIN:
  - Go to IDLE next cycle and discard any partial word.
  - If Abort coincides with WRITE, that write still occurs this cycle; no further writes follow.
  - No Done pulse; Error unchanged.
- Abort and Start both high in IDLE: Abort wins, Start is ignored.
- A byte presented with Byte_Valid while Byte_Ready=0 is held by the source, per handshake; the loader never drops an accepted byte.
- Reset mid-load: outputs return immediately to reset values; memory contents already written are left as-is.

Decomposition:
- Shared package: FSM state encoding (IDLE/RECV/WRITE/FIN), ADDR_W/DEPTH defaults, and the MIPS word width (32) as constants.
- One natural sub-module, byte_to_word_packer: the shift register plus 2-bit byte counter, with a word_valid output.
- The FSM, index counter and memory-write registers stay in the top level.

Test Plan:
- Reset check → after reset release, all outputs 0 and Byte_Ready=0.
- Length=2, bytes 20 08 00 05 8C 09 00 04 streamed with continuous valid:
  - first Mem_We: addr 0, data 0x20080005, one cycle after the 4th byte;
  - second Mem_We: addr 1, data 0x8C090004;
  - Done pulses one cycle after the last write; Cpu_Hold is high from the cycle after Start through the Done cycle.
- Same 2-word stream with Byte_Valid toggled 1/0 every cycle → identical writes and data, just later; no byte lost or duplicated; Mem_We asserted exactly 2 times.
- Length=0 → Done one cycle after FIN entry, zero writes, Error=0. Length=1025 → Error=1, no writes, no Done, Busy stays 0; a following Start with Length=1 clears Error.
- Length=3, Abort asserted after 6 bytes → exactly one write (addr 0), return to IDLE, no Done. A new load then writes starting from addr 0.
- Length=1024 with an incrementing pattern → last write at addr 1023, then Done. Start pulsed mid-load is ignored; Rst_n pulsed low mid-word → immediate IDLE, outputs reset.
